// File: rtl/csa_calc_dispatcher.sv
// Expands a job of N consecutive candidate inputs into work items and serves them
// to the CSA calc stage through a small first-word-fall-through queue.
module csa_calc_dispatcher #(
  parameter int unsigned AXI_DATA_WIDTH    = 32,
  parameter int unsigned CSA_CALC_IN_WIDTH = 48,
  parameter int unsigned QUEUE_DEPTH_LOG2  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  input  logic [AXI_DATA_WIDTH-1:0]    cfg_block,
  input  logic [CSA_CALC_IN_WIDTH-1:0] cfg_in_base,
  input  logic [AXI_DATA_WIDTH-1:0]    cfg_in_count,
  input  logic [AXI_DATA_WIDTH-1:0]    cfg_times,
  input  logic [AXI_DATA_WIDTH-1:0]    cfg_times_start,
  output logic                         busy,
  output logic                         done,
  output logic [AXI_DATA_WIDTH-1:0]    items_issued,
  output logic [AXI_DATA_WIDTH-1:0]    items_consumed,
  output logic                         fifo_ready,
  input  logic                         fifo_ren,
  output logic [AXI_DATA_WIDTH-1:0]    csa_calc_logic_block,
  output logic [CSA_CALC_IN_WIDTH-1:0] csa_calc_logic_in,
  output logic [AXI_DATA_WIDTH-1:0]    csa_calc_logic_times,
  output logic [AXI_DATA_WIDTH-1:0]    csa_calc_logic_times_start
);

  localparam int unsigned Depth = 1 << QUEUE_DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  typedef logic [QUEUE_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [QUEUE_DEPTH_LOG2:0]   occ_t;

  state_e                       state_q, state_d;
  logic [CSA_CALC_IN_WIDTH-1:0] mem_q [Depth];
  ptr_t                         wptr_q, rptr_q;
  occ_t                         occ_q, occ_d;
  logic [AXI_DATA_WIDTH-1:0]    issued_q, consumed_q, count_q;
  logic [AXI_DATA_WIDTH-1:0]    block_q, times_q, times_start_q;
  logic [CSA_CALC_IN_WIDTH-1:0] base_q, last_q, push_val;

  logic abort_hit, start_ok, push, pop, last_push;

  assign abort_hit = cfg_abort && (state_q != StIdle);
  assign start_ok  = cfg_start && (state_q == StIdle);
  // Push looks at registered occupancy only; a same-cycle pop never frees a slot.
  assign push      = (state_q == StRun) && !occ_q[QUEUE_DEPTH_LOG2] && !abort_hit;
  assign pop       = fifo_ren && (occ_q != '0) && !abort_hit;
  assign last_push = (issued_q + AXI_DATA_WIDTH'(1)) == count_q;
  assign push_val  = base_q + CSA_CALC_IN_WIDTH'(issued_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = (cfg_in_count == '0) ? StDone : StRun;
      StRun:   if (push && last_push) state_d = StDrain;
      StDrain: if (occ_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_hit) state_d = StIdle;
  end

  always_comb begin
    occ_d = occ_q + occ_t'(push) - occ_t'(pop);
    if (abort_hit) occ_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      occ_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      issued_q      <= '0;
      consumed_q    <= '0;
      count_q       <= '0;
      block_q       <= '0;
      times_q       <= '0;
      times_start_q <= '0;
      base_q        <= '0;
      last_q        <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      last_q  <= csa_calc_logic_in;
      if (abort_hit) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + ptr_t'(1);
        if (pop)  rptr_q <= rptr_q + ptr_t'(1);
      end
      if (start_ok) begin
        count_q       <= cfg_in_count;
        block_q       <= cfg_block;
        times_q       <= cfg_times;
        times_start_q <= cfg_times_start;
        base_q        <= cfg_in_base;
        issued_q      <= '0;
        consumed_q    <= '0;
      end else begin
        if (push) issued_q   <= issued_q + AXI_DATA_WIDTH'(1);
        if (pop)  consumed_q <= consumed_q + AXI_DATA_WIDTH'(1);
      end
    end
  end

  // Storage needs no reset: an empty queue shows last_q, never a slot.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_val;
  end

  assign busy                       = (state_q == StRun) || (state_q == StDrain);
  assign done                       = (state_q == StDone);
  assign fifo_ready                 = (occ_q != '0);
  assign items_issued               = issued_q;
  assign items_consumed             = consumed_q;
  assign csa_calc_logic_in          = fifo_ready ? mem_q[rptr_q] : last_q;
  assign csa_calc_logic_block       = block_q;
  assign csa_calc_logic_times       = times_q;
  assign csa_calc_logic_times_start = times_start_q;

endmodule

// File: tb/tb_csa_calc_dispatcher.sv
// Bench for csa_calc_dispatcher: directed job scenarios plus randomized jobs, every
// cycle compared against a queue-based behavioural model of the dispatcher.
module tb_csa_calc_dispatcher;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic        clk, rst_n;
  logic        cfg_start, cfg_abort, fifo_ren;
  logic [31:0] cfg_block, cfg_in_count, cfg_times, cfg_times_start;
  logic [47:0] cfg_in_base;
  logic        busy, done, fifo_ready;
  logic [31:0] items_issued, items_consumed;
  logic [31:0] csa_calc_logic_block, csa_calc_logic_times, csa_calc_logic_times_start;
  logic [47:0] csa_calc_logic_in;

  csa_calc_dispatcher dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .cfg_start                  (cfg_start),
    .cfg_abort                  (cfg_abort),
    .cfg_block                  (cfg_block),
    .cfg_in_base                (cfg_in_base),
    .cfg_in_count               (cfg_in_count),
    .cfg_times                  (cfg_times),
    .cfg_times_start            (cfg_times_start),
    .busy                       (busy),
    .done                       (done),
    .items_issued               (items_issued),
    .items_consumed             (items_consumed),
    .fifo_ready                 (fifo_ready),
    .fifo_ren                   (fifo_ren),
    .csa_calc_logic_block       (csa_calc_logic_block),
    .csa_calc_logic_in          (csa_calc_logic_in),
    .csa_calc_logic_times       (csa_calc_logic_times),
    .csa_calc_logic_times_start (csa_calc_logic_times_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int done_seen = 0;

  // Reference model: job phase, queue contents and counters.
  int          m_phase;
  logic [47:0] fq[$];
  logic [47:0] m_base, m_last;
  logic [31:0] m_n, m_issued, m_consumed, m_block, m_times, m_ts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    fq.delete();
    m_base = '0; m_last = '0; m_n = '0; m_issued = '0; m_consumed = '0;
    m_block = '0; m_times = '0; m_ts = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    int sz;
    bit pop, push;
    sz = fq.size();
    m_last = (sz != 0) ? fq[0] : m_last;
    if (cfg_abort && m_phase != P_IDLE) begin
      fq.delete();
      m_phase = P_IDLE;
    end else begin
      pop  = fifo_ren && (sz != 0);
      push = (m_phase == P_RUN) && (sz < DEPTH);
      if (pop) begin
        void'(fq.pop_front());
        m_consumed++;
      end
      case (m_phase)
        P_IDLE: if (cfg_start) begin
          m_base = cfg_in_base; m_n = cfg_in_count; m_block = cfg_block;
          m_times = cfg_times; m_ts = cfg_times_start;
          m_issued = 0; m_consumed = 0;
          m_phase = (cfg_in_count == 0) ? P_DONE : P_RUN;
        end
        P_RUN: if (push) begin
          fq.push_back(m_base + 48'(m_issued));
          m_issued++;
          if (m_issued == m_n) m_phase = P_DRAIN;
        end
        P_DRAIN: if (sz == 0) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check("busy", busy, (m_phase == P_RUN) || (m_phase == P_DRAIN));
    check("done", done, m_phase == P_DONE);
    check("fifo_ready", fifo_ready, fq.size() != 0);
    check("items_issued", items_issued, m_issued);
    check("items_consumed", items_consumed, m_consumed);
    check("head", csa_calc_logic_in, (fq.size() != 0) ? fq[0] : m_last);
    check("block", csa_calc_logic_block, m_block);
    check("times", csa_calc_logic_times, m_times);
    check("times_start", csa_calc_logic_times_start, m_ts);
    if (done) done_seen++;
  endtask

  task automatic tick(input bit start, input bit abort, input bit ren);
    cfg_start = start; cfg_abort = abort; fifo_ren = ren;
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    compare_all();
  endtask

  task automatic set_job(input logic [47:0] base, input logic [31:0] n,
                         input logic [31:0] times, input logic [31:0] ts);
    cfg_in_base = base; cfg_in_count = n; cfg_times = times; cfg_times_start = ts;
    cfg_block = $urandom;
  endtask

  task automatic run_to_idle(input int ren_pct, input int bound);
    int c = 0;
    while (m_phase != P_IDLE && c < bound) begin
      tick(1'b0, 1'b0, $urandom_range(99) < ren_pct);
      c++;
    end
    check("timeout_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; cfg_start = 0; cfg_abort = 0; fifo_ren = 0;
    set_job(48'h0, 32'd0, 32'd0, 32'd0);
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_ready", fifo_ready, 0);
    check("reset_in", csa_calc_logic_in, 0);
    tick(0, 0, 0);
    rst_n = 1'b1;
    tick(0, 0, 0);
    tick(0, 1, 1);  // abort in IDLE: no effect

    // Basic job
    set_job(48'h10, 32'd5, 32'd9, 32'd4);
    done_seen = 0;
    tick(1, 0, 1);
    check("basic_busy_after_start", busy, 1);
    tick(0, 0, 1);
    check("basic_first_item", csa_calc_logic_in, 48'h10);
    run_to_idle(100, 50);
    check("basic_consumed", items_consumed, 5);
    check("basic_done_count", done_seen, 1);
    check("basic_times", csa_calc_logic_times, 9);
    check("basic_times_start", csa_calc_logic_times_start, 4);

    // Backpressure
    set_job({16'h1234, 32'($urandom)}, 32'd10, 32'd1, 32'd2);
    tick(1, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);
    check("bp_issued", items_issued, 4);
    check("bp_ready", fifo_ready, 1);
    check("bp_head", csa_calc_logic_in, cfg_in_base);
    run_to_idle(100, 60);
    check("bp_consumed", items_consumed, 10);

    // Wrap
    set_job(48'hFFFF_FFFF_FFFE, 32'd3, 32'd7, 32'd0);
    tick(1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    check("wrap_item0", csa_calc_logic_in, 48'hFFFF_FFFF_FFFE);
    tick(0, 0, 1);
    check("wrap_item1", csa_calc_logic_in, 48'hFFFF_FFFF_FFFF);
    tick(0, 0, 1);
    check("wrap_item2", csa_calc_logic_in, 48'h0);
    run_to_idle(100, 20);

    // Zero-count job
    set_job(48'h55, 32'd0, 32'd3, 32'd3);
    tick(1, 0, 1);
    check("zero_done", done, 1);
    check("zero_ready", fifo_ready, 0);
    tick(0, 0, 1);
    check("zero_done_clear", done, 0);

    // Second start during RUN is ignored
    set_job(48'h200, 32'd6, 32'd11, 32'd12);
    tick(1, 0, 0);
    tick(0, 0, 0);
    set_job(48'h900, 32'd2, 32'd99, 32'd98);
    tick(1, 0, 0);
    check("restart_times", csa_calc_logic_times, 11);
    check("restart_head", csa_calc_logic_in, 48'h200);
    run_to_idle(100, 40);
    check("restart_issued", items_issued, 6);

    // Abort after three pops
    set_job(48'h300, 32'd8, 32'd5, 32'd6);
    done_seen = 0;
    tick(1, 0, 1);
    for (int i = 0; i < 20 && m_consumed < 3; i++) tick(0, 0, 1);
    tick(0, 1, 1);
    check("abort_ready", fifo_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_consumed", items_consumed, 3);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    check("abort_no_done", done_seen, 0);
    set_job(48'h400, 32'd4, 32'd1, 32'd1);
    tick(1, 0, 1);
    run_to_idle(100, 30);
    check("post_abort_consumed", items_consumed, 4);

    // Randomized jobs with random consumer and occasional abort
    for (int j = 0; j < 12; j++) begin
      int pct, abort_at, c;
      set_job({$urandom, $urandom}, $urandom_range(12), $urandom, $urandom);
      pct = $urandom_range(90, 25);
      abort_at = $urandom_range(60, 2);
      tick(1, 0, $urandom_range(99) < pct);
      c = 0;
      while (m_phase != P_IDLE && c < 200) begin
        tick(0, c == abort_at, $urandom_range(99) < pct);
        c++;
      end
      check("rand_idle", busy, 0);
      tick(0, 0, 0);
    end

    // Asynchronous reset mid-job
    set_job(48'h700, 32'd10, 32'd4, 32'd8);
    tick(1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, $urandom_range(1));
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", fifo_ready, 0);
    check("arst_issued", items_issued, 0);
    check("arst_consumed", items_consumed, 0);
    check("arst_in", csa_calc_logic_in, 0);
    check("arst_times", csa_calc_logic_times, 0);
    check("arst_block", csa_calc_logic_block, 0);
    model_reset();
    tick(0, 0, 0);
    #2 rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 5; i++) tick(0, 0, 1);
    check("arst_no_done", done_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
